// File: rtl/l1_mem_arbiter.sv
// rtl/l1_mem_arbiter.sv - round-robin arbiter sharing one memory port between L1 I and D controllers
module l1_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic              i_ack,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              timeout_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state;
  logic             owner_d;   // 1: D owns the port, 0: I owns it
  logic             last_d;    // 1: D was granted last, 0: I was
  logic [CNT_W-1:0] wd;
  logic             grant_d;
  logic             wd_expire;

  // D wins when it is alone or when I was served last; otherwise I wins
  assign grant_d   = d_req && (!i_req || !last_d);
  assign wd_expire = (TIMEOUT != 0) && (wd == CNT_W'(TIMEOUT - 1));

  // Arbitration FSM, memory port registers, acks and read-line returns
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      owner_d     <= 1'b0;
      last_d      <= 1'b0;
      wd          <= '0;
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      mem_cs      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req || d_req) begin
            owner_d   <= grant_d;
            mem_cs    <= 1'b1;
            mem_we    <= grant_d ? d_we    : i_we;
            mem_addr  <= grant_d ? d_addr  : i_addr;
            mem_wdata <= grant_d ? d_wdata : i_wdata;
            wd        <= '0;
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            // A real ack wins over a simultaneous watchdog expiry
            mem_cs <= 1'b0;
            if (owner_d) begin
              d_ack <= 1'b1;
              if (!mem_we) d_rdata <= mem_rdata;
            end else begin
              i_ack <= 1'b1;
              if (!mem_we) i_rdata <= mem_rdata;
            end
            last_d <= owner_d;
            state  <= S_RESP;
          end else if (wd_expire) begin
            // Hung memory: complete the owner with a zero line and flag it
            mem_cs      <= 1'b0;
            timeout_err <= 1'b1;
            if (owner_d) begin
              d_ack   <= 1'b1;
              d_rdata <= '0;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= '0;
            end
            last_d <= owner_d;
            state  <= S_RESP;
          end else begin
            wd <= wd + CNT_W'(1);
          end
        end
        S_RESP: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb/tb_l1_mem_arbiter.sv - directed self-checking bench for l1_mem_arbiter
module tb_l1_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0, i_we = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [LW-1:0] i_wdata = '0;
  logic          i_ack;
  logic [LW-1:0] i_rdata;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [LW-1:0] d_rdata;
  logic          mem_cs, mem_we;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [LW-1:0] mem_rdata = '0;
  logic          timeout_err;

  int errors = 0;
  int checks = 0;
  logic [LW-1:0] exp_i_rdata = '0;
  logic [LW-1:0] exp_d_rdata = '0;
  logic [LW-1:0] rd;

  always #5 clk = ~clk;

  l1_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the negedge where mem_cs is first seen high, bounded
  task automatic wait_cs();
    int n = 0;
    while (!mem_cs && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cs_seen", mem_cs, 1);
  endtask

  // Hold the port busy for lat cycles, checking held outputs, ack on the last one
  task automatic mem_serve(input int lat, input logic [LW-1:0] rdat,
                           input logic [AW-1:0] ea, input logic ewe, input logic [LW-1:0] ewd);
    for (int k = 1; k <= lat; k++) begin
      check("busy_cs", mem_cs, 1);
      check("busy_addr", mem_addr, ea);
      check("busy_we", mem_we, ewe);
      if (ewe) check("busy_wdata", mem_wdata, ewd);
      if (k == lat) begin
        mem_ack   = 1'b1;
        mem_rdata = rdat;
      end
      @(negedge clk);
    end
    mem_ack   = 1'b0;
    mem_rdata = {4{32'hDEADBEEF}};
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_cs", mem_cs, 0);
    check("rst_i_ack", i_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_d_rdata", d_rdata, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single read from D
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    @(negedge clk);
    check("rd_cs_latency", mem_cs, 1);
    rd = {16{8'hA5}};
    mem_serve(3, rd, 32'h100, 1'b0, '0);
    check("rd_cs_drop", mem_cs, 0);
    check("rd_d_ack", d_ack, 1);
    check("rd_i_ack", i_ack, 0);
    exp_d_rdata = rd;
    check("rd_d_rdata", d_rdata, exp_d_rdata);
    d_req = 1'b0;
    @(negedge clk);
    check("rd_ack_one_cycle", d_ack, 0);
    @(negedge clk);
    check("rd_no_reserve", mem_cs, 0);

    // Simultaneous requests from reset: D, I, D, I
    pulse_reset();
    i_addr = 32'h1000; i_we = 1'b0;
    d_addr = 32'h2000; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int t = 0; t < 4; t++) begin
      logic exp_d;
      exp_d = (t % 2 == 0);
      wait_cs();
      check("rr_owner_addr", mem_addr, exp_d ? 32'h2000 : 32'h1000);
      rd = {4{32'hC0DE0000 | 32'(t)}};
      mem_serve(2, rd, exp_d ? 32'h2000 : 32'h1000, 1'b0, '0);
      if (exp_d) exp_d_rdata = rd; else exp_i_rdata = rd;
      check("rr_d_ack", d_ack, exp_d);
      check("rr_i_ack", i_ack, !exp_d);
      check("rr_d_rdata", d_rdata, exp_d_rdata);
      check("rr_i_rdata", i_rdata, exp_i_rdata);
      if (exp_d) d_req = 1'b0; else i_req = 1'b0;
      @(negedge clk);
      check("rr_ack_clear", d_ack | i_ack, 0);
      if (t < 2) begin
        if (exp_d) d_req = 1'b1; else i_req = 1'b1;
      end
    end

    // Write-back from D; input changes during BUSY are ignored
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 128'h1234;
    wait_cs();
    d_wdata = 128'hFFFF; d_addr = 32'h999;
    mem_serve(3, {4{32'h5A5A5A5A}}, 32'h200, 1'b1, 128'h1234);
    check("wb_d_ack", d_ack, 1);
    check("wb_d_rdata_kept", d_rdata, exp_d_rdata);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);

    // Timeout on an I read: 4 BUSY cycles, then zero line and sticky error
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h300;
    wait_cs();
    for (int k = 0; k < 4; k++) begin
      check("to_cs_high", mem_cs, 1);
      @(negedge clk);
    end
    exp_i_rdata = '0;
    check("to_cs_drop", mem_cs, 0);
    check("to_i_ack", i_ack, 1);
    check("to_i_rdata", i_rdata, exp_i_rdata);
    check("to_err", timeout_err, 1);
    i_req = 1'b0;
    @(negedge clk);
    check("to_ack_clear", i_ack, 0);
    d_req = 1'b1; d_addr = 32'h240; d_we = 1'b0;
    wait_cs();
    rd = {4{32'h0BADF00D}};
    mem_serve(1, rd, 32'h240, 1'b0, '0);
    exp_d_rdata = rd;
    check("to_next_d_ack", d_ack, 1);
    check("to_next_d_rdata", d_rdata, exp_d_rdata);
    check("to_err_sticky", timeout_err, 1);
    d_req = 1'b0;
    @(negedge clk);

    // Stray ack while idle
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = {4{32'h77777777}};
    @(negedge clk);
    mem_ack = 1'b0;
    check("stray_cs", mem_cs, 0);
    check("stray_acks", i_ack | d_ack, 0);
    check("stray_d_rdata", d_rdata, exp_d_rdata);
    @(negedge clk);
    check("stray_idle", mem_cs, 0);

    // Reset in the middle of a transfer, then D wins the tie
    d_req = 1'b1; d_addr = 32'h400; d_we = 1'b0;
    wait_cs();
    @(negedge clk);
    rst = 1'b0;
    i_req = 1'b1; i_addr = 32'h500; i_we = 1'b0;
    #1;
    check("mrst_cs", mem_cs, 0);
    check("mrst_acks", i_ack | d_ack, 0);
    check("mrst_terr", timeout_err, 0);
    exp_i_rdata = '0; exp_d_rdata = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_grant_cs", mem_cs, 1);
    check("mrst_grant_d", mem_addr, 32'h400);
    rd = {4{32'h13579BDF}};
    mem_serve(2, rd, 32'h400, 1'b0, '0);
    exp_d_rdata = rd;
    check("mrst_d_ack", d_ack, 1);
    check("mrst_d_rdata", d_rdata, exp_d_rdata);
    d_req = 1'b0;
    @(negedge clk);
    wait_cs();
    check("mrst_then_i", mem_addr, 32'h500);
    rd = {4{32'h2468ACE0}};
    mem_serve(1, rd, 32'h500, 1'b0, '0);
    exp_i_rdata = rd;
    check("mrst_i_ack", i_ack, 1);
    check("mrst_i_rdata", i_rdata, exp_i_rdata);
    check("mrst_d_rdata_kept", d_rdata, exp_d_rdata);
    i_req = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l1_mem_arbiter.md
Name: l1_mem_arbiter

Overview:
- Shares the single external memory port between the L1 instruction-cache controller (I) and the L1 data-cache controller (D).
- Each cache controller issues line-fill (read) or write-back (write) requests. The arbiter grants one requester at a time, round-robin, and holds the grant until the memory acknowledges.
- It returns a one-cycle acknowledge and the read line to the winner.
- A watchdog converts a hung memory transaction into an acknowledge plus a sticky error, so neither cache deadlocks.

Parameters:
- ADDR_W, 32, address width (line-aligned byte address).
- LINE_W, 128, cache line width in bits.
- TIMEOUT, 255, max cycles to wait for mem_ack; 0 disables the watchdog.
- CNT_W, 8, watchdog counter width; must hold TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  I-side request; held until i_ack.
- i_we  in  1  I-side write (1) / read (0); stable while i_req.
- i_addr  in  ADDR_W  I-side line address.
- i_wdata  in  LINE_W  I-side write line.
- i_ack  out  1  I-side one-cycle completion pulse.
- i_rdata  out  LINE_W  I-side read line; valid when i_ack and read.
- d_req, d_we, d_addr, d_wdata, d_ack, d_rdata: same as the I-side, for the D-cache.
- mem_cs  out  1  external memory chip select.
- mem_we  out  1  external memory write enable.
- mem_addr  out  ADDR_W  external address.
- mem_wdata  out  LINE_W  external write line.
- mem_ack  in  1  external completion; mem_rdata valid in the same cycle for reads.
- mem_rdata  in  LINE_W  external read line.
- timeout_err  out  1  sticky; set on a watchdog expiry.

Behaviour:
- All outputs are registered.
- Reset (rst low, asynchronous, effective immediately, including mid-transaction):
  - all outputs 0;
  - state = IDLE; wd counter = 0;
  - last_grant = I, so D wins the first tie.
- States: IDLE, BUSY, RESP.
- IDLE:
  - No request -> stay in IDLE.
  - Only one requester active -> grant it.
  - Both active -> grant the one that is not last_grant.
  - On grant: latch that requester's we/addr/wdata into mem_we/mem_addr/mem_wdata, set mem_cs=1, record the owner, clear wd, go to BUSY.
  - Latency: request visible at edge N -> mem_cs=1 after edge N.
- BUSY:
  - mem_cs held at 1; mem_we/mem_addr/mem_wdata are held constant. Requester inputs are not re-sampled, so changes on them have no effect.
  - On mem_ack=1 at edge M:
    - mem_cs=0 and owner's ack=1 after edge M;
    - if the transaction is a read, owner's rdata loads mem_rdata; on a write, rdata holds its old value;
    - last_grant = owner; go to RESP.
  - Watchdog: wd increments every BUSY cycle. When TIMEOUT!=0 and wd reaches TIMEOUT-1 with no mem_ack:
    - mem_cs=0; owner's ack=1; owner's rdata loads 0;
    - timeout_err=1 (sticky until reset);
    - last_grant = owner; go to RESP.
  - mem_ack and expiry on the same edge -> treated as a normal ack; timeout_err is not set.
- RESP (exactly one cycle):
  - Owner's ack=1 for this cycle only; deasserted at the next edge; go to IDLE.
  - The requester must drop its req on the edge where it samples ack=1, so IDLE never re-serves it.
  - A pending request from the other side is granted in the next IDLE cycle.
- Minimum spacing between mem_cs assertions is one idle cycle (RESP) plus the IDLE decision cycle.
- mem_ack while mem_cs=0 (IDLE/RESP) is ignored.
- The non-owner's ack is never asserted, and its rdata is unchanged.
- Requests arriving during BUSY/RESP wait. Fairness: with both requesting continuously, grants alternate D, I, D, I.

Test Plan:
- Single read: after reset, d_req=1, d_we=0, d_addr=0x100. Memory acks 3 cycles after mem_cs with rdata=0xA5..A5 -> mem_cs high for 3 cycles with mem_addr=0x100, mem_we=0; d_ack pulses for 1 cycle with d_rdata=0xA5..A5; i_ack stays 0.
- Simultaneous requests: i_req and d_req raised on the same cycle -> D served first, then I with mem_addr=i_addr. Repeated back-to-back, grants alternate D, I, D, I across 4 transactions.
- Write-back: d_we=1, d_addr=0x200, d_wdata=0x1234 -> mem_we=1, mem_wdata=0x1234 for the whole BUSY period. After d_ack, d_rdata keeps its previous value.
- Timeout: TIMEOUT=4, i_req read, mem_ack never asserted -> mem_cs drops after 4 BUSY cycles; i_ack pulses with i_rdata=0; timeout_err=1 and stays 1. A following d_req completes normally.
- Reset mid-transfer: rst low during BUSY -> mem_cs, acks and timeout_err go to 0 immediately. After rst high, a pending d_req is granted (D wins the tie).
- Stray ack: pulse mem_ack while idle -> no ack outputs and no state change.
